remote_comm_mb: RTL and testbench

- Parametrised multi-byte command transmitter with response tracking. Successor to the fixed 2-byte remote command sender.
- Serialises a CMD_BYTES-wide command MSB-byte-first over a byte-level UART interface (trmt/tx_data/tx_done).
- Waits for a single response byte (rx_rdy/rx_data) and flags a timeout if none arrives within TIMEOUT_CYC cycles.
- Sits between the host/test logic and the shared UART instance.

---
 rtl/remote_comm_pkg.sv | 27 ++
 rtl/remote_comm_mb_if.sv | 22 ++
 rtl/rc_timeout_cnt.sv | 31 +++
 rtl/remote_comm_mb.sv | 148 ++++++++++++++
 tb/tb_remote_comm_mb.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/remote_comm_pkg.sv
// Shared types, widths and checksum helper for the multi-byte remote command sender.
// rc_chksum is only referenced when REMOTE_COMM_CHKSUM_EN is defined.
package remote_comm_pkg;

    localparam int BYTE_W        = 8;
    localparam int MAX_CMD_BYTES = 8;
    localparam int MAX_CMD_W     = MAX_CMD_BYTES * BYTE_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        SEND      = 2'd2,
        WAIT_RESP = 2'd3
    } rc_state_t;

    // Byte that makes the mod-256 sum of the low nbytes of data plus itself equal zero.
    function automatic logic [BYTE_W-1:0] rc_chksum(input logic [MAX_CMD_W-1:0] data,
                                                     input int                   nbytes);
        logic [BYTE_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < MAX_CMD_BYTES; i++) begin
            if (i < nbytes) sum = sum + data[i*BYTE_W +: BYTE_W];
        end
        return BYTE_W'(0) - sum;
    endfunction

endpackage

// File: rtl/remote_comm_mb_if.sv
// Byte-level UART handshake between the command sender (master) and the shared UART (slave).
interface remote_comm_mb_if;
    import remote_comm_pkg::*;

    logic              trmt;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_done;
    logic              rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic              clr_rx_rdy;

    modport master (
        output trmt, tx_data, clr_rx_rdy,
        input  tx_done, rx_rdy, rx_data
    );

    modport slave (
        input  trmt, tx_data, clr_rx_rdy,
        output tx_done, rx_rdy, rx_data
    );

endinterface

// File: rtl/rc_timeout_cnt.sv
// Saturating response-timeout counter with synchronous clear and terminal-count flag.
module rc_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    // NOTE: registered state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT_VAL)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/remote_comm_mb.sv
// Serialises a CMD_BYTES command MSB-first over a byte UART, then waits for one response byte.
// Define REMOTE_COMM_CHKSUM_EN to append a two's-complement checksum byte to each command.
module remote_comm_mb
    import remote_comm_pkg::*;
#(
    parameter int CMD_BYTES   = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        send_cmd,
    input  logic [BYTE_W*CMD_BYTES-1:0] cmd,
    output logic                        busy,
    output logic                        cmd_sent,
    output logic                        resp_rdy,
    output logic [BYTE_W-1:0]           resp,
    output logic                        resp_timeout,
    remote_comm_mb_if.master            uart
);

`ifdef REMOTE_COMM_CHKSUM_EN
    localparam int NBYTES = CMD_BYTES + 1;
`else
    localparam int NBYTES = CMD_BYTES;
`endif
    localparam int               SHIFT_W  = NBYTES * BYTE_W;
    localparam int               CNT_W    = $clog2(CMD_BYTES + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    rc_state_t state, state_nxt;

    logic [SHIFT_W-1:0] shift_q;
    logic [SHIFT_W-1:0] load_value;
    logic [CNT_W-1:0]   byte_cnt;
    logic               trmt_q;
    logic [BYTE_W-1:0]  tx_data_q;
    logic               clr_rx_q;
    logic               last_byte;
    logic               tc;

    // Control strobes decoded from the current state.
    logic accept;
    logic load_byte;
    logic advance;
    logic finish_tx;
    logic take_resp;
    logic time_out;

`ifdef REMOTE_COMM_CHKSUM_EN
    assign load_value = {cmd, rc_chksum(MAX_CMD_W'(cmd), CMD_BYTES)};
`else
    assign load_value = cmd;
`endif

    assign last_byte = (byte_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (send_cmd) state_nxt = LOAD;
            LOAD:      state_nxt = SEND;
            SEND:      if (uart.tx_done) state_nxt = last_byte ? WAIT_RESP : LOAD;
            WAIT_RESP: if (uart.rx_rdy || tc) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        load_byte = 1'b0;
        advance   = 1'b0;
        finish_tx = 1'b0;
        take_resp = 1'b0;
        time_out  = 1'b0;
        case (state)
            IDLE:      accept    = send_cmd;
            LOAD:      load_byte = 1'b1;
            SEND: begin
                finish_tx = uart.tx_done &&  last_byte;
                advance   = uart.tx_done && !last_byte;
            end
            WAIT_RESP: begin
                // A response arriving on the terminal cycle beats the timeout.
                take_resp = uart.rx_rdy;
                time_out  = !uart.rx_rdy && tc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q      <= '0;
            byte_cnt     <= '0;
            trmt_q       <= 1'b0;
            tx_data_q    <= '0;
            clr_rx_q     <= 1'b0;
            cmd_sent     <= 1'b0;
            resp_rdy     <= 1'b0;
            resp         <= '0;
            resp_timeout <= 1'b0;
        end else begin
            trmt_q   <= load_byte;
            // Bytes arriving outside WAIT_RESP are consumed and dropped.
            clr_rx_q <= uart.rx_rdy;
            if (accept) begin
                shift_q      <= load_value;
                byte_cnt     <= '0;
                cmd_sent     <= 1'b0;
                resp_rdy     <= 1'b0;
                resp_timeout <= 1'b0;
            end
            if (load_byte) tx_data_q <= shift_q[SHIFT_W-1 -: BYTE_W];
            if (advance) begin
                shift_q  <= shift_q << BYTE_W;
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
            if (finish_tx) cmd_sent <= 1'b1;
            if (take_resp) begin
                resp     <= uart.rx_data;
                resp_rdy <= 1'b1;
            end
            if (time_out) resp_timeout <= 1'b1;
        end
    end

    rc_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (finish_tx),
        .en    (state == WAIT_RESP),
        .tc    (tc)
    );

    assign busy            = (state != IDLE);
    assign uart.trmt       = trmt_q;
    assign uart.tx_data    = tx_data_q;
    assign uart.clr_rx_rdy = clr_rx_q;

endmodule

// File: tb/tb_remote_comm_mb.sv
// Bench for remote_comm_mb: a 2-byte/20-cycle-timeout DUT and a 4-byte DUT, both checked each cycle
// against a timestamp-based behavioural model, plus literal expectations for the directed scenarios.
module tb_remote_comm_mb;

    localparam int CB_A = 2;
    localparam int CB_B = 4;
    localparam int TO_A = 20;
    localparam int TO_B = 100;
    localparam int LAT_A = 3;
    localparam int LAT_B = 10;
`ifdef REMOTE_COMM_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        send_cmd [2];
    logic [15:0] cmd_a;
    logic [31:0] cmd_b;
    logic        tx_done  [2];
    logic        rx_rdy   [2];
    logic [7:0]  rx_data  [2];

    logic        busy     [2];
    logic        cmd_sent [2];
    logic        resp_rdy [2];
    logic [7:0]  resp     [2];
    logic        resp_to  [2];
    logic        trmt     [2];
    logic [7:0]  tx_data  [2];
    logic        clr_rx   [2];

    int n_checks = 0;
    int n_fail   = 0;

    remote_comm_mb_if if_a ();
    remote_comm_mb_if if_b ();

    assign if_a.tx_done = tx_done[0];
    assign if_a.rx_rdy  = rx_rdy[0];
    assign if_a.rx_data = rx_data[0];
    assign if_b.tx_done = tx_done[1];
    assign if_b.rx_rdy  = rx_rdy[1];
    assign if_b.rx_data = rx_data[1];
    assign trmt[0]    = if_a.trmt;
    assign tx_data[0] = if_a.tx_data;
    assign clr_rx[0]  = if_a.clr_rx_rdy;
    assign trmt[1]    = if_b.trmt;
    assign tx_data[1] = if_b.tx_data;
    assign clr_rx[1]  = if_b.clr_rx_rdy;

    remote_comm_mb #(.CMD_BYTES(CB_A), .TIMEOUT_CYC(TO_A)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .send_cmd (send_cmd[0]), .cmd (cmd_a),
        .busy (busy[0]), .cmd_sent (cmd_sent[0]), .resp_rdy (resp_rdy[0]),
        .resp (resp[0]), .resp_timeout (resp_to[0]), .uart (if_a)
    );

    remote_comm_mb #(.CMD_BYTES(CB_B), .TIMEOUT_CYC(TO_B)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .send_cmd (send_cmd[1]), .cmd (cmd_b),
        .busy (busy[1]), .cmd_sent (cmd_sent[1]), .resp_rdy (resp_rdy[1]),
        .resp (resp[1]), .resp_timeout (resp_to[1]), .uart (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (event timestamps, edge-indexed) ----------------
    int         cyc = 0;
    bit         m_busy     [2];
    bit         m_inflight [2];
    bit         m_waiting  [2];
    int         m_trmt_at  [2];
    int         m_wstart   [2];
    int         m_idx      [2];
    int         m_nb       [2];
    logic [7:0] m_bytes    [2][9];
    bit         e_trmt [2];
    bit         e_clr  [2];
    bit         e_sent [2];
    bit         e_rdy  [2];
    bit         e_to   [2];
    logic [7:0] e_txd  [2];
    logic [7:0] e_resp [2];

    task automatic model_step(input int d);
        logic [63:0] c;
        logic [7:0]  sum;
        int          cb;
        int          to;
        cb = (d == 0) ? CB_A : CB_B;
        to = (d == 0) ? TO_A : TO_B;
        c  = (d == 0) ? 64'(cmd_a) : 64'(cmd_b);
        e_trmt[d] = 1'b0;
        e_clr[d]  = 1'b0;
        if (!rst_n) begin
            m_busy[d] = 0; m_inflight[d] = 0; m_waiting[d] = 0; m_trmt_at[d] = -1;
            e_txd[d] = '0; e_sent[d] = 0; e_rdy[d] = 0; e_resp[d] = '0; e_to[d] = 0;
        end else begin
            e_clr[d] = rx_rdy[d];
            if (!m_busy[d]) begin
                if (send_cmd[d]) begin
                    sum = '0;
                    for (int i = 0; i < cb; i++) begin
                        m_bytes[d][i] = c[8*(cb-1-i) +: 8];
                        sum = sum + m_bytes[d][i];
                    end
                    m_bytes[d][cb] = 8'h00 - sum;
                    m_nb[d] = cb + CHK;
                    m_idx[d] = 0;
                    m_busy[d] = 1;
                    m_trmt_at[d] = cyc + 1;
                    e_sent[d] = 0; e_rdy[d] = 0; e_to[d] = 0;
                end
            end else if (m_trmt_at[d] == cyc) begin
                e_trmt[d] = 1'b1;
                e_txd[d] = m_bytes[d][m_idx[d]];
                m_inflight[d] = 1;
                m_trmt_at[d] = -1;
            end else if (m_inflight[d]) begin
                if (tx_done[d]) begin
                    m_inflight[d] = 0;
                    m_idx[d]++;
                    if (m_idx[d] == m_nb[d]) begin
                        e_sent[d] = 1;
                        m_waiting[d] = 1;
                        m_wstart[d] = cyc;
                    end else begin
                        m_trmt_at[d] = cyc + 1;
                    end
                end
            end else if (m_waiting[d]) begin
                if (rx_rdy[d]) begin
                    e_resp[d] = rx_data[d]; e_rdy[d] = 1; m_waiting[d] = 0; m_busy[d] = 0;
                end else if (cyc - m_wstart[d] == to) begin
                    e_to[d] = 1; m_waiting[d] = 0; m_busy[d] = 0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    // ---------------- compare process and byte log ----------------
    logic [7:0] log_a [$];
    logic [7:0] log_b [$];
    int         cyc_b [$];

    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int d = 0; d < 2; d++) begin
                    check("busy",         d, 32'(busy[d]),     32'(m_busy[d]));
                    check("trmt",         d, 32'(trmt[d]),     32'(e_trmt[d]));
                    check("tx_data",      d, 32'(tx_data[d]),  32'(e_txd[d]));
                    check("clr_rx_rdy",   d, 32'(clr_rx[d]),   32'(e_clr[d]));
                    check("cmd_sent",     d, 32'(cmd_sent[d]), 32'(e_sent[d]));
                    check("resp_rdy",     d, 32'(resp_rdy[d]), 32'(e_rdy[d]));
                    check("resp",         d, 32'(resp[d]),     32'(e_resp[d]));
                    check("resp_timeout", d, 32'(resp_to[d]),  32'(e_to[d]));
                end
                if (trmt[0] === 1'b1) log_a.push_back(tx_data[0]);
                if (trmt[1] === 1'b1) begin
                    log_b.push_back(tx_data[1]);
                    cyc_b.push_back(cyc);
                end
            end
        end
    end

    // ---------------- UART tx_done responder ----------------
    int rsp_cnt [2];

    initial begin
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
        tx_done[0] = 1'b0;
        tx_done[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                tx_done[d] = 1'b0;
                if (rsp_cnt[d] > 0) begin
                    rsp_cnt[d]--;
                    if (rsp_cnt[d] == 0) tx_done[d] = 1'b1;
                end
                if (trmt[d] === 1'b1) rsp_cnt[d] = ((d == 0) ? LAT_A : LAT_B) - 1;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse_send(input int d, input logic [31:0] c);
        if (d == 0) cmd_a = c[15:0];
        else        cmd_b = c;
        send_cmd[d] = 1'b1;
        @(negedge clk);
        send_cmd[d] = 1'b0;
    endtask

    task automatic rx_pulse(input int d, input logic [7:0] b);
        rx_data[d] = b;
        rx_rdy[d]  = 1'b1;
        @(negedge clk);
        rx_rdy[d]  = 1'b0;
    endtask

    task automatic wait_sent(input int d, input int budget);
        int k = 0;
        while (cmd_sent[d] !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_cmd_sent", d, 32'(cmd_sent[d]), 32'd1);
    endtask

    task automatic check_log(input int d, input int start, input logic [39:0] bytes, input int n);
        int sz;
        sz = (d == 0) ? log_a.size() : log_b.size();
        check("byte_count", d, 32'(sz - start), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (start + i < sz)
                check("byte_value", d, 32'((d == 0) ? log_a[start+i] : log_b[start+i]),
                      32'(bytes[8*(n-1-i) +: 8]));
        end
    endtask

    initial begin
        int s;
        int k;
        rst_n = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        for (int d = 0; d < 2; d++) begin
            send_cmd[d] = 1'b0;
            rx_rdy[d]   = 1'b0;
            rx_data[d]  = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_busy",    0, 32'(busy[0]),    32'd0);
        check("reset_trmt",    1, 32'(trmt[1]),    32'd0);
        check("reset_tx_data", 1, 32'(tx_data[1]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2-byte command, no response: timeout exactly TO_A cycles after entering WAIT_RESP.
        s = log_a.size();
        pulse_send(0, 32'hA55A);
        wait_sent(0, 100);
        k = 0;
        while (resp_to[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_latency", 0, 32'(k), 32'd20);
        check_log(0, s, (CHK != 0) ? 40'hA55A01 : 40'hA55A, 2 + CHK);

        // New command clears the timeout; response on the terminal cycle wins.
        s = log_a.size();
        pulse_send(0, 32'h1234);
        @(negedge clk);
        check("timeout_cleared", 0, 32'(resp_to[0]), 32'd0);
        wait_sent(0, 100);
        repeat (19) @(negedge clk);
        rx_pulse(0, 8'h3C);
        check("terminal_resp_rdy",     0, 32'(resp_rdy[0]), 32'd1);
        check("terminal_resp",         0, 32'(resp[0]),     32'h3C);
        check("terminal_resp_timeout", 0, 32'(resp_to[0]),  32'd0);
        check_log(0, s, (CHK != 0) ? 40'h1234BA : 40'h1234, 2 + CHK);

        // Byte discarded while idle leaves the captured response untouched.
        rx_pulse(0, 8'h77);
        @(negedge clk);
        check("idle_rx_resp", 0, 32'(resp[0]), 32'h3C);

        // 4-byte command with 10-cycle UART; response at cycle 50 of WAIT_RESP.
        s = log_b.size();
        pulse_send(1, 32'h01020304);
        wait_sent(1, 300);
        repeat (49) @(negedge clk);
        rx_pulse(1, 8'hA5);
        check("resp_value",   1, 32'(resp[1]),     32'hA5);
        check("resp_rdy",     1, 32'(resp_rdy[1]), 32'd1);
        check("resp_no_to",   1, 32'(resp_to[1]),  32'd0);
        check("resp_idle",    1, 32'(busy[1]),     32'd0);
        check_log(1, s, (CHK != 0) ? 40'h01020304F6 : 40'h01020304, 4 + CHK);
        for (int i = 1; i < 4 + CHK; i++) begin
            if (s + i < cyc_b.size())
                check("trmt_spacing", 1, 32'(cyc_b[s+i] - cyc_b[s+i-1]), 32'd11);
        end

        // send_cmd re-pulsed mid-SEND is ignored.
        s = log_b.size();
        pulse_send(1, 32'hDEADBEEF);
        k = 0;
        while (log_b.size() == s && k < 20) begin
            @(negedge clk);
            k++;
        end
        pulse_send(1, 32'h11111111);
        wait_sent(1, 300);
        rx_pulse(1, 8'h5A);
        check_log(1, s, (CHK != 0) ? 40'hDEADBEEFC8 : 40'hDEADBEEF, 4 + CHK);

        // Reset mid-SEND: outputs cleared and no further trmt.
        s = log_a.size();
        pulse_send(0, 32'h0F0F);
        k = 0;
        while (log_a.size() == s && k < 20) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy",     0, 32'(busy[0]),     32'd0);
        check("rst_tx_data",  0, 32'(tx_data[0]),  32'd0);
        check("rst_resp",     0, 32'(resp[0]),     32'd0);
        check("rst_resp_rdy", 0, 32'(resp_rdy[0]), 32'd0);
        s = log_a.size();
        repeat (20) @(negedge clk);
        check("rst_no_trmt", 0, 32'(log_a.size()), 32'(s));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
